// File: rtl/systolic_skew_feeder_pkg.sv
// Shared definitions for the systolic skew feeder: gauss op codes, FSM states
// and a counter-width helper.
package systolic_skew_feeder_pkg;

    localparam logic [1:0] GOP_PASS = 2'b00;
    localparam logic [1:0] GOP_LOAD = 2'b01;
    localparam logic [1:0] GOP_ADD  = 2'b10;
    localparam logic [1:0] GOP_HOLD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_DRAIN = 2'b10
    } fsm_state_t;

    // Bits needed to hold a count from 0 to n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_skew_delay_line.sv
// Fixed-depth register chain used as one skewed lane; the output is always the
// last stage, so even DEPTH=1 has no combinational input-to-output path.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift the lane word one stage per cycle; reset empties the whole chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Row-to-diagonal feeder for the GF systolic array: accepts whole rows and
// drives column c delayed by c cycles, with start/gauss-op sideband per lane.
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int GF_BIT       = 4,
    parameter int OP_CODE_LEN  = 4,
    parameter int NUM_PROC_COL = 3,
    parameter int ROW_CNT_W    = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_start,
    input  logic [ROW_CNT_W-1:0]           cfg_num_rows,
    input  logic [OP_CODE_LEN-1:0]         cfg_op,
    input  logic [1:0]                     cfg_gauss_op,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_PROC_COL*GF_BIT-1:0] in_data,
    output logic [NUM_PROC_COL*GF_BIT-1:0] out_data,
    output logic [NUM_PROC_COL-1:0]        out_start,
    output logic [2*NUM_PROC_COL-1:0]      out_gauss_op,
    output logic [OP_CODE_LEN-1:0]         op_out,
    output logic                           busy,
    output logic                           done
);

    localparam int LANE_W = GF_BIT + 3;
    localparam int DRN_W  = cnt_width(NUM_PROC_COL);
    localparam logic [DRN_W-1:0] DRAIN_INIT = DRN_W'(NUM_PROC_COL - 1);

    fsm_state_t             r_state;
    logic [ROW_CNT_W-1:0]   r_rows_left;
    logic [DRN_W-1:0]       r_drain;
    logic [OP_CODE_LEN-1:0] r_op;
    logic [1:0]             r_gop;
    logic                   r_first;
    logic                   r_busy;
    logic                   r_done;
    logic                   w_accept;

    assign in_ready = (r_state == ST_LOAD);
    assign w_accept = in_ready && in_valid;

    // Job sequencing: latch config, count accepted rows, then wait for the
    // last diagonal to reach the final lane before pulsing done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rows_left <= '0;
            r_drain     <= '0;
            r_op        <= '0;
            r_gop       <= GOP_PASS;
            r_first     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (cfg_start) begin
                        r_op        <= cfg_op;
                        r_gop       <= cfg_gauss_op;
                        r_rows_left <= cfg_num_rows;
                        r_first     <= 1'b1;
                        r_busy      <= 1'b1;
                        if (cfg_num_rows == '0) begin
                            r_state <= ST_DRAIN;
                            r_drain <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_first <= 1'b0;
                        if ((r_rows_left == ROW_CNT_W'(1)) || (r_rows_left == '0)) begin
                            r_rows_left <= '0;
                            r_state     <= ST_DRAIN;
                            r_drain     <= DRAIN_INIT;
                            r_done      <= (DRAIN_INIT == '0);
                        end else begin
                            r_rows_left <= r_rows_left - ROW_CNT_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // done is raised one cycle early so it is registered in
                    // the cycle the final lane shows the last row.
                    if (r_drain == '0) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_drain <= r_drain - DRN_W'(1);
                        r_done  <= (r_drain == DRN_W'(1));
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign op_out = r_op;
    assign busy   = r_busy;
    assign done   = r_done;

    // One delay line per column; bubbles enter as an all-zero lane word.
    for (genvar c = 0; c < NUM_PROC_COL; c++) begin : g_lane
        logic [LANE_W-1:0] w_lane_in;
        logic [LANE_W-1:0] w_lane_out;

        assign w_lane_in = w_accept ? {r_first, r_gop, in_data[c*GF_BIT +: GF_BIT]}
                                    : {LANE_W{1'b0}};

        skew_delay_line #(
            .DEPTH(c + 1),
            .WIDTH(LANE_W)
        ) u_delay (
            .clk(clk),
            .rst(rst),
            .i_d(w_lane_in),
            .o_q(w_lane_out)
        );

        assign out_data[c*GF_BIT +: GF_BIT] = w_lane_out[GF_BIT-1:0];
        assign out_gauss_op[2*c +: 2]       = w_lane_out[GF_BIT +: 2];
        assign out_start[c]                 = w_lane_out[GF_BIT+2];
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Randomized bench for systolic_skew_feeder against a slot-indexed schedule
// model: each accepted row is scattered onto future (slot, lane) positions.
module tb_systolic_skew_feeder;

    localparam int GFB  = 4;
    localparam int OPW  = 4;
    localparam int NCOL = 3;
    localparam int RCW  = 8;
    localparam int QD   = 64;

    logic                 clk;
    logic                 rst;
    logic                 cfg_start;
    logic [RCW-1:0]       cfg_num_rows;
    logic [OPW-1:0]       cfg_op;
    logic [1:0]           cfg_gauss_op;
    logic                 in_valid;
    logic                 in_ready;
    logic [NCOL*GFB-1:0]  in_data;
    logic [NCOL*GFB-1:0]  out_data;
    logic [NCOL-1:0]      out_start;
    logic [2*NCOL-1:0]    out_gauss_op;
    logic [OPW-1:0]       op_out;
    logic                 busy;
    logic                 done;

    systolic_skew_feeder #(
        .GF_BIT(GFB), .OP_CODE_LEN(OPW), .NUM_PROC_COL(NCOL), .ROW_CNT_W(RCW)
    ) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_num_rows(cfg_num_rows),
        .cfg_op(cfg_op), .cfg_gauss_op(cfg_gauss_op), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_data(out_data),
        .out_start(out_start), .out_gauss_op(out_gauss_op), .op_out(op_out),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int slot = 0;

    // Reference model: job bookkeeping plus a per-slot, per-lane schedule.
    bit             m_load;
    int             m_left;
    bit             m_first;
    logic [OPW-1:0] m_op;
    logic [1:0]     m_gop;
    int             m_done_slot;
    logic [GFB-1:0] s_data [QD][NCOL];
    logic [1:0]     s_gop  [QD][NCOL];
    logic           s_start[QD][NCOL];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s slot=%0d got=0x%0h exp=0x%0h", tag, slot, got, exp);
        end
    endtask

    task automatic model_clear();
        m_load      = 1'b0;
        m_left      = 0;
        m_first     = 1'b0;
        m_op        = '0;
        m_gop       = 2'b00;
        m_done_slot = -1;
        for (int i = 0; i < QD; i++) begin
            for (int c = 0; c < NCOL; c++) begin
                s_data[i][c]  = '0;
                s_gop[i][c]   = 2'b00;
                s_start[i][c] = 1'b0;
            end
        end
    endtask

    function automatic bit model_idle();
        return !m_load && (slot > m_done_slot);
    endfunction

    task automatic check_outputs();
        logic [NCOL*GFB-1:0] ed;
        logic [2*NCOL-1:0]   eg;
        logic [NCOL-1:0]     es;
        int                  ix;
        ix = slot % QD;
        for (int c = 0; c < NCOL; c++) begin
            ed[c*GFB +: GFB] = s_data[ix][c];
            eg[2*c +: 2]     = s_gop[ix][c];
            es[c]            = s_start[ix][c];
            s_data[ix][c]  = '0;
            s_gop[ix][c]   = 2'b00;
            s_start[ix][c] = 1'b0;
        end
        check_val("out_data", 32'(out_data), 32'(ed));
        check_val("out_gauss_op", 32'(out_gauss_op), 32'(eg));
        check_val("out_start", 32'(out_start), 32'(es));
        check_val("in_ready", 32'(in_ready), 32'(m_load));
        check_val("busy", 32'(busy), 32'(m_load || (slot <= m_done_slot)));
        check_val("done", 32'(done), 32'(slot == m_done_slot));
        check_val("op_out", 32'(op_out), 32'(m_op));
    endtask

    // Predict the effect of the coming edge from the current inputs, take the
    // edge, then compare everything at the following falling edge.
    task automatic tick();
        int e;
        e = slot + 1;
        if (m_load && in_valid) begin
            for (int c = 0; c < NCOL; c++) begin
                s_data[(e + c) % QD][c]  = in_data[c*GFB +: GFB];
                s_gop[(e + c) % QD][c]   = m_gop;
                s_start[(e + c) % QD][c] = m_first;
            end
            m_first = 1'b0;
            m_left--;
            if (m_left == 0) begin
                m_load      = 1'b0;
                m_done_slot = e + NCOL - 1;
            end
        end else if (model_idle() && cfg_start) begin
            m_op  = cfg_op;
            m_gop = cfg_gauss_op;
            if (cfg_num_rows == '0) begin
                m_done_slot = e;
            end else begin
                m_load  = 1'b1;
                m_left  = int'(cfg_num_rows);
                m_first = 1'b1;
            end
        end
        @(posedge clk);
        slot++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic reset_async();
        rst = 1'b1;
        #1;
        check_val("rst_out_data", 32'(out_data), 32'd0);
        check_val("rst_out_start", 32'(out_start), 32'd0);
        check_val("rst_out_gop", 32'(out_gauss_op), 32'd0);
        check_val("rst_op_out", 32'(op_out), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        model_clear();
        @(posedge clk);
        slot++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_job(input int n, input logic [OPW-1:0] op, input logic [1:0] gop);
        cfg_start    = 1'b1;
        cfg_num_rows = RCW'(n);
        cfg_op       = op;
        cfg_gauss_op = gop;
        in_valid     = 1'b0;
        tick();
        cfg_start    = 1'b0;
    endtask

    task automatic send_row(input logic [NCOL*GFB-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        in_valid = 1'b0;
        while (!model_idle() && n < 40) begin
            tick();
            n++;
        end
        tick();
    endtask

    initial begin
        rst          = 1'b1;
        cfg_start    = 1'b0;
        cfg_num_rows = '0;
        cfg_op       = '0;
        cfg_gauss_op = 2'b00;
        in_valid     = 1'b0;
        in_data      = '0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
        tick();

        // Two back-to-back rows.
        start_job(2, 4'h3, 2'b10);
        send_row(12'h321);
        send_row(12'h654);
        wait_idle();

        // Same job with a bubble between the rows.
        start_job(2, 4'h5, 2'b10);
        send_row(12'h321);
        tick();
        send_row(12'h654);
        wait_idle();

        // Empty job.
        start_job(0, 4'h7, 2'b11);
        in_valid = 1'b1;
        in_data  = 12'hFFF;
        tick();
        tick();
        wait_idle();

        // A second cfg_start mid-load must not disturb the running job.
        start_job(5, 4'b1010, 2'b01);
        send_row(12'h111);
        cfg_start = 1'b1;
        cfg_op    = 4'b1110;
        send_row(12'h222);
        cfg_start = 1'b0;
        for (int r = 0; r < 4; r++) begin
            send_row(12'(32'h333 + r * 32'h111));
        end
        wait_idle();

        // Reset mid-load with lanes populated, then a fresh one-row job.
        start_job(3, 4'h9, 2'b11);
        send_row(12'h987);
        reset_async();
        tick();
        start_job(1, 4'h4, 2'b01);
        send_row(12'hABC);
        wait_idle();

        // Randomized jobs with random bubbles, stray starts and resets.
        for (int j = 0; j < 30; j++) begin
            start_job(int'($urandom_range(0, 6)), OPW'($urandom), 2'($urandom));
            for (int k = 0; k < 40 && m_load; k++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_data   = (NCOL*GFB)'($urandom);
                cfg_start = ($urandom_range(0, 7) == 0);
                cfg_op    = OPW'($urandom);
                tick();
                cfg_start = 1'b0;
                if ($urandom_range(0, 30) == 0) begin
                    reset_async();
                end
            end
            wait_idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream stage of the GF systolic processor array.
- Accepts whole rows of NUM_PROC_COL field elements over a valid/ready handshake and drives the top edge of the array, one lane per processor column.
- Column c is delayed c cycles (diagonal skew) so that wavefronts align at each processor.
- Generates per-lane start and gauss_op sideband and a job-level op code, and signals job completion once the last diagonal has been emitted.

Parameters:
- GF_BIT, 4, element width (4 or 8).
- OP_CODE_LEN, 4, op code width.
- NUM_PROC_COL, 3, array columns (>=1).
- ROW_CNT_W, 8, width of the job row counter.

Ports:
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- cfg_start  in  1  job start pulse; sampled in IDLE only.
- cfg_num_rows  in  ROW_CNT_W  rows in the job.
- cfg_op  in  OP_CODE_LEN  op code for the job.
- cfg_gauss_op  in  2  gauss op applied to valid data lanes.
- in_valid  in  1  row valid.
- in_ready  out  1  row accepted when in_valid&&in_ready.
- in_data  in  NUM_PROC_COL*GF_BIT  row; element c at [c*GF_BIT +: GF_BIT].
- out_data  out  NUM_PROC_COL*GF_BIT  skewed lanes, same packing.
- out_start  out  NUM_PROC_COL  per-lane start (first row only).
- out_gauss_op  out  2*NUM_PROC_COL  per-lane gauss op; lane c at [2c +: 2].
- op_out  out  OP_CODE_LEN  latched cfg_op.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst=1):
  - state IDLE; all lane registers, row counter and drain counter cleared.
  - out_data=0, out_start=0, out_gauss_op=0, op_out=0, in_ready=0, busy=0, done=0.
- FSM states: IDLE, LOAD, DRAIN.
- IDLE:
  - cfg_start=1 latches cfg_op into op_out, cfg_gauss_op internally, and cfg_num_rows as rows_left.
  - If cfg_num_rows=0, go to DRAIN with drain count already expired: done pulses the next cycle, then return to IDLE. in_ready never rises.
  - Otherwise go to LOAD.
- LOAD:
  - in_ready=1 (combinational from state).
  - Each accepted beat decrements rows_left.
  - The accept that takes rows_left from 1 to 0 moves the FSM to DRAIN, and in_ready drops the next cycle.
- DRAIN:
  - Counts NUM_PROC_COL-1 cycles.
  - done=1 in the cycle the last row's column NUM_PROC_COL-1 element is on out_data, then the FSM returns to IDLE.
  - busy=1 from the cycle after cfg_start up to and including the done cycle.
- Skew timing: row accepted at edge t places element c on lane c during cycle t+1+c. Every lane is registered; there is no combinational in_data to out_data path.
- Lane sideband:
  - A lane carrying a valid element shows cfg_gauss_op.
  - A lane with no data (bubble, idle, or drained) shows data 0 and gauss op 2'b00 (pass).
  - out_start[c] is 1 only alongside the first row's element on lane c.
- Bubbles: in_valid=0 during LOAD injects an empty row that propagates diagonally like data; rows_left is unchanged.
- Ordering: every lane tap advances each cycle, so skew, start and gauss_op stay aligned per diagonal.
- cfg_start during LOAD or DRAIN is ignored; latched config is unchanged.
- Reset mid-job: immediate abort, all lanes zeroed; no done pulse. A fresh cfg_start after deassertion runs normally.
- Row counter never underflows; rows_left=0 in LOAD is unreachable.

Decomposition:
- Shared package/define file holds:
  - gauss op constants: GOP_PASS=2'b00, GOP_LOAD=2'b01, GOP_ADD=2'b10, GOP_HOLD=2'b11.
  - FSM state encodings (IDLE/LOAD/DRAIN).
- Sub-module skew_delay_line (params DEPTH, WIDTH):
  - a register chain with async reset to 0, instantiated per lane with DEPTH=c+1.
  - WIDTH=GF_BIT+3 carries {start, gauss_op, data} together.

Test Plan:
- Reset: assert rst mid-simulation with lanes non-zero -> all outputs 0 in the same cycle; in_ready=0, busy=0.
- Two-row job, defaults: cfg_start with num_rows=2, gauss_op=2'b10; rows 12'h321 at edge t, 12'h654 at t+1 ->
  - lane0 = 1 at t+1, 4 at t+2; lane1 = 2 at t+2, 5 at t+3; lane2 = 3 at t+3, 6 at t+4.
  - out_start[c] high only at t+1+c.
  - gauss 10 only on valid slots, 00 elsewhere.
  - done at t+4, busy low at t+5.
- Bubble: same job with in_valid=0 for one cycle between the rows -> an empty diagonal (data 0, gauss 00) between the rows on every lane; done delayed by one cycle.
- Empty job: num_rows=0 -> done pulses the cycle after cfg_start; in_ready stays 0; lanes stay 0.
- Busy protection: cfg_start with num_rows=5, op=4'b1010 pulsed again mid-LOAD with op=4'b1110 -> op_out stays 1010; exactly 5 rows accepted.
- Reset mid-LOAD after 1 of 3 rows -> lanes clear, no done. A new job with num_rows=1, row 12'hABC -> A,B,C on lanes 2,1,0 respectively, at cycles +3, +2, +1.
